// File: rtl/pythag_pkg.sv
// Shared constants and FSM state encoding for the Pythagorean leg solver.
// A result appears LATENCY enabled edges after the edge that accepts start.
package pythag_pkg;

    localparam int WIDTH   = 8;
    localparam int LATENCY = 3 * WIDTH + 2;
    localparam int CNT_W   = $clog2(WIDTH);

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_SQ_R = 3'd1;
    localparam state_t S_SQ_X = 3'd2;
    localparam state_t S_SUB  = 3'd3;
    localparam state_t S_ROOT = 3'd4;
    localparam state_t S_FIN  = 3'd5;

endpackage

// File: rtl/pythag_leg_solver_seq_squarer.sv
// Multiplier-free sequential squarer, one partial product per enabled cycle.
// The load cycle already folds in bit 0, so valid rises after WIDTH-1 en cycles.
module seq_squarer #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               en,
    input  logic [WIDTH-1:0]   a,
    output logic [2*WIDTH-1:0] sq,
    output logic               valid
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    assign valid = (cnt == CW'(WIDTH));
    assign sq    = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= a[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand  <= {{WIDTH{1'b0}}, a} << 1;
            mplier <= a >> 1;
            cnt    <= CW'(1);
        end else if (en && !valid) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pythag_leg_solver.sv
// Computes floor(sqrt(r*r - x*x)) with shift-add squaring and a restoring root.
// Sits behind a start/busy/done handshake; ena=0 freezes every register.
//
// state  | meaning
// IDLE   | waiting for start
// SQ_R   | squaring r; last cycle stores r*r and loads x
// SQ_X   | squaring x
// SUB    | diff = r*r - x*x, or 0 with invalid pending when x > r
// ROOT   | one root bit per cycle, MSB first
// FIN    | publish result, pulse done, drop busy
module pythag_leg_solver
    import pythag_pkg::*;
#(
    parameter int WIDTH = pythag_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] hyp_in,
    input  logic [WIDTH-1:0] leg_in,
    output logic [WIDTH-1:0] leg_out,
    output logic             busy,
    output logic             done,
    output logic             invalid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    logic [WIDTH-1:0]   hyp_q;
    logic [WIDTH-1:0]   leg_q;
    logic [2*WIDTH-1:0] r2_q;
    logic [2*WIDTH-1:0] rad_q;
    logic [WIDTH+3:0]   rem_q;
    logic [WIDTH-1:0]   root_q;
    logic [CW-1:0]      cnt_q;
    logic               inv_pend;

    logic               sq_load;
    logic               sq_en;
    logic               sq_valid;
    logic [WIDTH-1:0]   sq_a;
    logic [2*WIDTH-1:0] sq;

    logic [WIDTH+3:0]   rem_sh;
    logic [WIDTH+3:0]   trial;
    logic [WIDTH+3:0]   rem_nx;
    logic [WIDTH-1:0]   root_nx;

    // The squarer is shared: r is loaded on acceptance, x on the last SQ_R cycle.
    assign sq_load = ena && (((state == S_IDLE) && start) ||
                             ((state == S_SQ_R) && sq_valid));
    assign sq_en   = ena && ((state == S_SQ_R) || (state == S_SQ_X));
    assign sq_a    = (state == S_IDLE) ? hyp_in : leg_q;

    seq_squarer #(
        .WIDTH (WIDTH)
    ) u_squarer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sq_load),
        .en    (sq_en),
        .a     (sq_a),
        .sq    (sq),
        .valid (sq_valid)
    );

    always_comb begin
        rem_sh  = (rem_q << 2) | {{(WIDTH+2){1'b0}}, rad_q[2*WIDTH-1 -: 2]};
        trial   = {2'b00, root_q, 2'b01};
        rem_nx  = rem_sh;
        root_nx = root_q << 1;
        if (rem_sh >= trial) begin
            rem_nx  = rem_sh - trial;
            root_nx = (root_q << 1) | {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hyp_q    <= '0;
            leg_q    <= '0;
            r2_q     <= '0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            inv_pend <= 1'b0;
            leg_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            invalid  <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        hyp_q <= hyp_in;
                        leg_q <= leg_in;
                        busy  <= 1'b1;
                        state <= S_SQ_R;
                    end
                end
                S_SQ_R: begin
                    if (sq_valid) begin
                        r2_q  <= sq;
                        state <= S_SQ_X;
                    end
                end
                S_SQ_X: begin
                    if (sq_valid) begin
                        state <= S_SUB;
                    end
                end
                S_SUB: begin
                    if (leg_q > hyp_q) begin
                        rad_q    <= '0;
                        inv_pend <= 1'b1;
                    end else begin
                        rad_q    <= r2_q - sq;
                        inv_pend <= 1'b0;
                    end
                    rem_q  <= '0;
                    root_q <= '0;
                    cnt_q  <= '0;
                    state  <= S_ROOT;
                end
                S_ROOT: begin
                    rad_q  <= rad_q << 2;
                    rem_q  <= rem_nx;
                    root_q <= root_nx;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    leg_out <= root_q;
                    invalid <= inv_pend;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pythag_leg_solver.sv
// Directed bench for pythag_leg_solver: a vector table plus hand-written
// sequences for ignored starts, back-to-back runs, stalls and mid-run reset.
module tb_pythag_leg_solver;
    import pythag_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [7:0] hyp_in;
    logic [7:0] leg_in;
    logic [7:0] leg_out;
    logic       busy;
    logic       done;
    logic       invalid;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] prev_leg;
    logic       prev_inv;

    typedef struct {
        logic [7:0] r;
        logic [7:0] x;
        logic [7:0] leg;
        logic       inv;
    } vec_t;

    vec_t vecs [13];

    pythag_leg_solver #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (start),
        .hyp_in  (hyp_in),
        .leg_in  (leg_in),
        .leg_out (leg_out),
        .busy    (busy),
        .done    (done),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < max);
    endtask

    // Returns just after the accepting edge E0.
    task automatic launch(input logic [7:0] r, input logic [7:0] x);
        @(negedge clk);
        hyp_in = r;
        leg_in = x;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_vec(input logic [7:0] r, input logic [7:0] x,
                           input logic [7:0] exp_leg, input logic exp_inv);
        int n;
        launch(r, x);
        chk($sformatf("busy_rise r=%0d x=%0d", r, x), busy, 1);
        chk($sformatf("hold_leg r=%0d x=%0d", r, x), leg_out, prev_leg);
        chk($sformatf("hold_inv r=%0d x=%0d", r, x), invalid, prev_inv);
        wait_done(60, n);
        chk($sformatf("latency r=%0d x=%0d", r, x), n, LATENCY);
        chk($sformatf("leg r=%0d x=%0d", r, x), leg_out, exp_leg);
        chk($sformatf("invalid r=%0d x=%0d", r, x), invalid, exp_inv);
        chk($sformatf("busy_fall r=%0d x=%0d", r, x), busy, 0);
        @(posedge clk);
        #1;
        chk($sformatf("done_pulse r=%0d x=%0d", r, x), done, 0);
        prev_leg = exp_leg;
        prev_inv = exp_inv;
    endtask

    initial begin
        int n;
        int m;
        vecs[0]  = '{8'd5,   8'd3,   8'd4,   1'b0};
        vecs[1]  = '{8'd255, 8'd0,   8'd255, 1'b0};
        vecs[2]  = '{8'd7,   8'd2,   8'd6,   1'b0};
        vecs[3]  = '{8'd10,  8'd10,  8'd0,   1'b0};
        vecs[4]  = '{8'd3,   8'd5,   8'd0,   1'b1};
        vecs[5]  = '{8'd5,   8'd4,   8'd3,   1'b0};
        vecs[6]  = '{8'd13,  8'd12,  8'd5,   1'b0};
        vecs[7]  = '{8'd0,   8'd0,   8'd0,   1'b0};
        vecs[8]  = '{8'd255, 8'd255, 8'd0,   1'b0};
        vecs[9]  = '{8'd200, 8'd120, 8'd160, 1'b0};
        vecs[10] = '{8'd100, 8'd1,   8'd99,  1'b0};
        vecs[11] = '{8'd1,   8'd255, 8'd0,   1'b1};
        vecs[12] = '{8'd255, 8'd254, 8'd22,  1'b0};

        rst_n  = 1'b0;
        ena    = 1'b1;
        start  = 1'b0;
        hyp_in = '0;
        leg_in = '0;
        prev_leg = '0;
        prev_inv = 1'b0;
        #12;
        chk("reset_leg", leg_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_invalid", invalid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i].r, vecs[i].x, vecs[i].leg, vecs[i].inv);
        end

        // Start pulse and input changes mid-run are ignored; start in the done cycle is taken.
        launch(8'd13, 8'd5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        hyp_in = 8'd1;
        leg_in = 8'd1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        hyp_in = 8'd200;
        leg_in = 8'd100;
        wait_done(60, n);
        chk("ignore_start_latency", n + 5, LATENCY);
        chk("ignore_start_leg", leg_out, 12);
        chk("ignore_start_inv", invalid, 0);
        hyp_in = 8'd5;
        leg_in = 8'd3;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_done_clear", done, 0);
        chk("b2b_busy", busy, 1);
        wait_done(60, n);
        chk("b2b_latency", n, LATENCY);
        chk("b2b_leg", leg_out, 4);
        @(posedge clk);
        #1;

        // Stall for 10 edges inside ROOT, then stall again across the done cycle.
        launch(8'd13, 8'd12);
        repeat (20) @(posedge clk);
        #1;
        ena = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("stall_busy", busy, 1);
        ena = 1'b1;
        wait_done(60, m);
        chk("stall_latency", 30 + m, LATENCY + 10);
        chk("stall_leg", leg_out, 5);
        ena = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_done_held", done, 1);
        chk("stall_leg_held", leg_out, 5);
        ena = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_done_clear", done, 0);

        // Asynchronous reset mid-run aborts with no later done.
        launch(8'd13, 8'd5);
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_leg", leg_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_invalid", invalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(30, n);
        chk("abort_no_done", done, 0);
        prev_leg = '0;
        prev_inv = 1'b0;
        run_vec(8'd5, 8'd3, 8'd4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
